// File: rtl/t04_pkg.sv
// Shared opcode encodings, reset instruction and sequencer state type
// for the t04 multi-cycle RV32I core.
package t04_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // ADDI x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } seq_state_t;

endpackage

// File: rtl/t04_opclass.sv
// Combinational opcode classifier: tells the sequencer which phases and
// side effects an instruction needs. Unknown opcodes classify as a
// harmless NOP with legal=0.
module t04_opclass
    import t04_pkg::*;
(
    input  logic [6:0] opcode_i,
    output logic       writes_rd_o,
    output logic       is_load_o,
    output logic       is_store_o,
    output logic       is_ctrl_o,
    output logic       is_system_o,
    output logic       legal_o
);

    // Decode opcode into class flags
    always_comb begin
        writes_rd_o = 1'b0;
        is_load_o   = 1'b0;
        is_store_o  = 1'b0;
        is_ctrl_o   = 1'b0;
        is_system_o = 1'b0;
        legal_o     = 1'b1;
        case (opcode_i)
            OP_LUI, OP_AUIPC, OP_IMM, OP_OP: writes_rd_o = 1'b1;
            OP_JAL, OP_JALR: begin
                writes_rd_o = 1'b1;
                is_ctrl_o   = 1'b1;
            end
            OP_BRANCH: is_ctrl_o = 1'b1;
            OP_LOAD: begin
                writes_rd_o = 1'b1;
                is_load_o   = 1'b1;
            end
            OP_STORE:  is_store_o  = 1'b1;
            OP_FENCE:  ;
            OP_SYSTEM: is_system_o = 1'b1;
            default:   legal_o     = 1'b0;
        endcase
    end

endmodule

// File: rtl/t04_instr_sequencer.sv
// Multi-cycle control FSM for the t04 core: owns PC and IR, steps each
// instruction through FETCH, DECODE, EXEC, optional MEM and WB. All
// strobes and requests are registered alongside the state.
module t04_instr_sequencer
    import t04_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic        en,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic [6:0]  opcode,
    input  logic        dmem_ack,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] pc,
    output logic        imem_req,
    output logic [31:0] instr,
    output logic        ir_valid,
    output logic        exec_en,
    output logic        dmem_ren,
    output logic        dmem_wen,
    output logic        reg_wen,
    output logic        illegal,
    output logic        halted
);

    seq_state_t  state_q;
    logic [31:0] pc_q, pc_d, ir_q;
    logic        imem_req_q, ir_valid_q, exec_en_q;
    logic        dmem_ren_q, dmem_wen_q, reg_wen_q, illegal_q, halted_q;

    logic writes_rd, is_load, is_store, is_ctrl, is_system, legal;

    t04_opclass u_opclass (
        .opcode_i    (opcode),
        .writes_rd_o (writes_rd),
        .is_load_o   (is_load),
        .is_store_o  (is_store),
        .is_ctrl_o   (is_ctrl),
        .is_system_o (is_system),
        .legal_o     (legal)
    );

    // Next PC: word-aligned target only for taken control transfers
    always_comb begin
        pc_d = pc_q + 32'd4;
        if (branch_taken && is_ctrl) begin
            pc_d = branch_target & 32'hFFFF_FFFC;
        end
    end

    // Sequencer FSM with PC/IR and registered strobes
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            ir_q       <= NOP_INSTR;
            imem_req_q <= 1'b0;
            ir_valid_q <= 1'b0;
            exec_en_q  <= 1'b0;
            dmem_ren_q <= 1'b0;
            dmem_wen_q <= 1'b0;
            reg_wen_q  <= 1'b0;
            illegal_q  <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (en) begin
                        state_q    <= S_FETCH;
                        imem_req_q <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        ir_q       <= imem_rdata;
                        imem_req_q <= 1'b0;
                        ir_valid_q <= 1'b1;
                        state_q    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    exec_en_q <= 1'b1;
                    state_q   <= S_EXEC;
                end
                S_EXEC: begin
                    exec_en_q <= 1'b0;
                    if (!legal) begin
                        illegal_q <= 1'b1;
                    end
                    if (is_load || is_store) begin
                        dmem_ren_q <= is_load;
                        dmem_wen_q <= is_store;
                        state_q    <= S_MEM;
                    end else begin
                        reg_wen_q <= writes_rd;
                        state_q   <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        dmem_ren_q <= 1'b0;
                        dmem_wen_q <= 1'b0;
                        reg_wen_q  <= writes_rd;
                        state_q    <= S_WB;
                    end
                end
                S_WB: begin
                    reg_wen_q  <= 1'b0;
                    ir_valid_q <= 1'b0;
                    pc_q       <= pc_d;
                    if (is_system) begin
                        halted_q <= 1'b1;
                        state_q  <= S_HALT;
                    end else if (en) begin
                        imem_req_q <= 1'b1;
                        state_q    <= S_FETCH;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_HALT: state_q <= S_HALT;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign pc       = pc_q;
    assign instr    = ir_q;
    assign imem_req = imem_req_q;
    assign ir_valid = ir_valid_q;
    assign exec_en  = exec_en_q;
    assign dmem_ren = dmem_ren_q;
    assign dmem_wen = dmem_wen_q;
    assign reg_wen  = reg_wen_q;
    assign illegal  = illegal_q;
    assign halted   = halted_q;

endmodule

// File: tb/tb_t04_instr_sequencer.sv
// Scoreboard bench for t04_instr_sequencer: directed instructions push
// their hand-computed retirement record; a monitor accumulates strobe
// activity per instruction and compares when ir_valid falls.
module tb_t04_instr_sequencer;

    logic        clk = 1'b0;
    logic        nRst;
    logic        en;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [6:0]  opcode;
    logic        dmem_ack;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] pc;
    logic        imem_req;
    logic [31:0] instr;
    logic        ir_valid, exec_en, dmem_ren, dmem_wen, reg_wen, illegal, halted;

    t04_instr_sequencer #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .nRst          (nRst),
        .en            (en),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .opcode        (opcode),
        .dmem_ack      (dmem_ack),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .pc            (pc),
        .imem_req      (imem_req),
        .instr         (instr),
        .ir_valid      (ir_valid),
        .exec_en       (exec_en),
        .dmem_ren      (dmem_ren),
        .dmem_wen      (dmem_wen),
        .reg_wen       (reg_wen),
        .illegal       (illegal),
        .halted        (halted)
    );

    // Stand-in for t04_decode
    assign opcode = instr[6:0];

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        int          rw, ren, wen, lat;
        logic        ill, hlt, nreq;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Retirement monitor
    initial begin
        int   a_req, a_iv, a_ren, a_wen, a_rw, a_ex, a_both;
        logic prev_iv;
        exp_t e;
        a_req = 0; a_iv = 0; a_ren = 0; a_wen = 0; a_rw = 0; a_ex = 0; a_both = 0;
        prev_iv = 1'b0;
        forever begin
            @(negedge clk);
            if (!nRst) begin
                prev_iv = 1'b0;
                a_req = 0; a_iv = 0; a_ren = 0; a_wen = 0; a_rw = 0; a_ex = 0; a_both = 0;
            end else begin
                if (prev_iv && !ir_valid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_retire", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("pc",           pc,                  e.pc);
                        check("reg_wen_cnt",  32'(a_rw),           32'(e.rw));
                        check("dmem_ren_cnt", 32'(a_ren),          32'(e.ren));
                        check("dmem_wen_cnt", 32'(a_wen),          32'(e.wen));
                        check("ren_wen_both", 32'(a_both),         32'd0);
                        check("exec_en_cnt",  32'(a_ex),           32'd1);
                        check("latency",      32'(a_req + a_iv),   32'(e.lat));
                        check("illegal",      {31'd0, illegal},    {31'd0, e.ill});
                        check("halted",       {31'd0, halted},     {31'd0, e.hlt});
                        check("next_req",     {31'd0, imem_req},   {31'd0, e.nreq});
                    end
                    a_req = 0; a_iv = 0; a_ren = 0; a_wen = 0; a_rw = 0; a_ex = 0; a_both = 0;
                end
                a_req  += int'(imem_req);
                a_iv   += int'(ir_valid);
                a_ren  += int'(dmem_ren);
                a_wen  += int'(dmem_wen);
                a_rw   += int'(reg_wen);
                a_ex   += int'(exec_en);
                a_both += int'(dmem_ren && dmem_wen);
                prev_iv = ir_valid;
            end
        end
    end

    // Issue one instruction with given memory wait profile and expectation
    task automatic run_instr(input logic [31:0] word, input int iw, input int dw,
                             input logic bt, input logic [31:0] tgt, input logic drop_en,
                             input logic [31:0] e_pc, input int e_rw, input int e_ren,
                             input int e_wen, input logic e_ill, input logic e_hlt,
                             input int e_lat, input logic e_nreq);
        exp_t e;
        int   n, mcnt;
        e.pc = e_pc; e.rw = e_rw; e.ren = e_ren; e.wen = e_wen;
        e.ill = e_ill; e.hlt = e_hlt; e.lat = e_lat; e.nreq = e_nreq;
        exp_q.push_back(e);
        branch_taken  = bt;
        branch_target = tgt;
        n = 0;
        while (!imem_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!imem_req) check("fetch_timeout", 32'd1, 32'd0);
        repeat (iw) @(negedge clk);
        imem_ack   = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        imem_ack = 1'b0;
        n = 0;
        mcnt = 0;
        while (ir_valid && n < 50) begin
            if (drop_en && exec_en) en = 1'b0;
            if (dmem_ren || dmem_wen) begin
                mcnt++;
                dmem_ack = (mcnt == dw);
            end else begin
                dmem_ack = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        dmem_ack = 1'b0;
        if (ir_valid) check("retire_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int cnt;
        nRst = 1'b0; en = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0;
        dmem_ack = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_pc",       pc,                 32'h0000_0000);
        check("rst_instr",    instr,              32'h0000_0013);
        check("rst_imem_req", {31'd0, imem_req},  32'd0);
        check("rst_ir_valid", {31'd0, ir_valid},  32'd0);
        check("rst_flags",    {30'd0, illegal, halted}, 32'd0);
        nRst = 1'b1;
        @(negedge clk);
        check("idle_no_req",  {31'd0, imem_req},  32'd0);
        en = 1'b1;

        // word, iw, dw, bt, tgt, drop_en, pc, rw, ren, wen, ill, hlt, lat, nreq
        run_instr(32'h0050_0093, 0, 0, 1'b0, 32'h0,         1'b0, 32'h0000_0004, 1, 0, 0, 1'b0, 1'b0, 4, 1'b1); // ADDI
        run_instr(32'h0000_A103, 3, 2, 1'b0, 32'h0,         1'b0, 32'h0000_0008, 1, 2, 0, 1'b0, 1'b0, 9, 1'b1); // LW
        run_instr(32'h0020_A023, 0, 1, 1'b0, 32'h0,         1'b0, 32'h0000_000C, 0, 0, 1, 1'b0, 1'b0, 5, 1'b1); // SW
        run_instr(32'h0000_0063, 0, 0, 1'b1, 32'h0000_0102, 1'b0, 32'h0000_0100, 0, 0, 0, 1'b0, 1'b0, 4, 1'b1); // BEQ taken
        run_instr(32'h0000_0063, 0, 0, 1'b0, 32'h0000_0200, 1'b0, 32'h0000_0104, 0, 0, 0, 1'b0, 1'b0, 4, 1'b1); // BEQ not taken
        run_instr(32'h0020_81B3, 0, 0, 1'b1, 32'h0000_0300, 1'b0, 32'h0000_0108, 1, 0, 0, 1'b0, 1'b0, 4, 1'b1); // ADD, taken ignored
        run_instr(32'h0000_007F, 0, 0, 1'b1, 32'h0000_0400, 1'b0, 32'h0000_010C, 0, 0, 0, 1'b1, 1'b0, 4, 1'b1); // illegal
        run_instr(32'h0000_006F, 0, 0, 1'b1, 32'h0000_0040, 1'b0, 32'h0000_0040, 1, 0, 0, 1'b1, 1'b0, 4, 1'b1); // JAL
        run_instr(32'h0000_8067, 0, 0, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFC, 1, 0, 0, 1'b1, 1'b0, 4, 1'b1); // JALR, masked
        run_instr(32'h0050_0093, 0, 0, 1'b0, 32'h0,         1'b0, 32'h0000_0000, 1, 0, 0, 1'b1, 1'b0, 4, 1'b1); // ADDI wrap
        run_instr(32'h0050_0093, 1, 0, 1'b0, 32'h0,         1'b1, 32'h0000_0004, 1, 0, 0, 1'b1, 1'b0, 5, 1'b0); // en dropped in EXEC

        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            cnt += int'(imem_req);
        end
        check("idle_after_en_drop", 32'(cnt), 32'd0);

        // Reset while a load is waiting in MEM
        en = 1'b1;
        cnt = 0;
        while (!imem_req && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        imem_ack = 1'b1;
        imem_rdata = 32'h0000_A103;
        @(negedge clk);
        imem_ack = 1'b0;
        cnt = 0;
        while (!dmem_ren && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check("mem_reached", {31'd0, dmem_ren}, 32'd1);
        nRst = 1'b0;
        en = 1'b0;
        #1;
        check("rstmem_dmem_ren", {31'd0, dmem_ren}, 32'd0);
        check("rstmem_pc",       pc,                32'h0000_0000);
        check("rstmem_ir_valid", {31'd0, ir_valid}, 32'd0);
        check("rstmem_illegal",  {31'd0, illegal},  32'd0);
        check("rstmem_instr",    instr,             32'h0000_0013);
        @(negedge clk);
        nRst = 1'b1;
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            cnt += int'(imem_req);
        end
        check("rstmem_idle", 32'(cnt), 32'd0);
        en = 1'b1;

        run_instr(32'h0000_0073, 0, 0, 1'b0, 32'h0, 1'b0, 32'h0000_0004, 0, 0, 0, 1'b0, 1'b1, 4, 1'b0); // ECALL
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            cnt += int'(imem_req);
        end
        check("halt_no_req", 32'(cnt), 32'd0);
        check("halt_sticky", {31'd0, halted}, 32'd1);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
